alu_result_fifo: RTL and testbench

- Downstream stage of the 32-bit ALU; buffers the ALU's result word and its flag bits (carry, overflow, zero) together with the 3-bit command that produced them.
- Decouples the ALU from the writeback/consumer stage through a valid/ready FIFO.
- Keeps sticky arithmetic status (carry, overflow) and a saturating overflow-event counter that software or a controller can clear.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_flag_tracker.sv | 51 +++++
 rtl/alu_result_fifo.sv | 113 +++++++++++
 tb/tb_alu_result_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU command codes, FIFO entry tag layout and command helpers.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_OR   = 3'b111
    } alu_cmd_e;

    // Upper part of a FIFO entry; the full entry is {alu_tag_t, result}.
    typedef struct packed {
        logic [2:0] cmd;
        logic       zero;
        logic       overflow;
        logic       cout;
    } alu_tag_t;

    localparam int ALU_TAG_W = $bits(alu_tag_t);

    function automatic logic is_arith(input logic [2:0] cmd);
        return (cmd == ALU_ADD) || (cmd == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_flag_tracker.sv
// rtl/alu_flag_tracker.sv - sticky carry/overflow bits and saturating overflow-event counter.
module alu_flag_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             cout,
    input  logic             overflow,
    input  logic             clear_sticky,
    output logic             sticky_carry,
    output logic             sticky_overflow,
    output logic [CNT_W-1:0] ovf_events
);

    logic             r_sticky_c;
    logic             r_sticky_o;
    logic [CNT_W-1:0] r_events;

    logic             w_c_next;
    logic             w_o_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    // Clear is applied first so a same-cycle setting push still lands.
    always_comb begin
        w_c_next   = (clear_sticky ? 1'b0 : r_sticky_c) | (push & cout);
        w_o_next   = (clear_sticky ? 1'b0 : r_sticky_o) | (push & overflow);
        w_cnt_base = clear_sticky ? '0 : r_events;
        w_cnt_next = w_cnt_base;
        if (push && overflow && (w_cnt_base != {CNT_W{1'b1}}))
            w_cnt_next = w_cnt_base + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_c <= 1'b0;
            r_sticky_o <= 1'b0;
            r_events   <= '0;
        end else begin
            r_sticky_c <= w_c_next;
            r_sticky_o <= w_o_next;
            r_events   <= w_cnt_next;
        end
    end

    assign sticky_carry    = r_sticky_c;
    assign sticky_overflow = r_sticky_o;
    assign ovf_events      = r_events;

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - first-word fall-through FIFO between the ALU and writeback.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [2:0]               in_cmd,
    input  logic                     in_cout,
    input  logic                     in_overflow,
    input  logic                     in_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [2:0]               out_cmd,
    output logic                     out_cout,
    output logic                     out_overflow,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sticky_carry,
    output logic                     sticky_overflow,
    output logic [CNT_W-1:0]         ovf_events,
    input  logic                     clear_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = WIDTH + ALU_TAG_W;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_cout_m;
    logic             w_ovf_m;
    alu_tag_t         w_in_tag;
    logic [ENT_W-1:0] w_head;
    alu_tag_t         w_head_tag;

    assign in_ready  = (r_count != (PTR_W+1)'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Carry and overflow are meaningless for logic ops, so they are dropped at the door.
    assign w_cout_m = in_cout & is_arith(in_cmd);
    assign w_ovf_m  = in_overflow & is_arith(in_cmd);

    always_comb begin
        w_in_tag          = '0;
        w_in_tag.cmd      = in_cmd;
        w_in_tag.zero     = in_zero;
        w_in_tag.overflow = w_ovf_m;
        w_in_tag.cout     = w_cout_m;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_in_tag, in_result};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stale memory contents are never exposed: outputs are gated by out_valid.
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_tag = alu_tag_t'(w_head[WIDTH +: ALU_TAG_W]);

    assign out_result   = out_valid ? w_head[WIDTH-1:0]   : '0;
    assign out_cmd      = out_valid ? w_head_tag.cmd      : 3'b000;
    assign out_cout     = out_valid & w_head_tag.cout;
    assign out_overflow = out_valid & w_head_tag.overflow;
    assign out_zero     = out_valid & w_head_tag.zero;
    assign count        = r_count;

    alu_flag_tracker #(
        .CNT_W (CNT_W)
    ) u_flags (
        .clk             (clk),
        .rst             (reset),
        .push            (w_push),
        .cout            (w_cout_m),
        .overflow        (w_ovf_m),
        .clear_sticky    (clear_sticky),
        .sticky_carry    (sticky_carry),
        .sticky_overflow (sticky_overflow),
        .ovf_events      (ovf_events)
    );

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - directed vector bench for alu_result_fifo.
module tb_alu_result_fifo;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_result;
    logic [2:0]  in_cmd;
    logic        in_cout;
    logic        in_overflow;
    logic        in_zero;
    logic        out_ready;
    logic        clear_sticky;

    logic        in_ready, out_valid, out_cout, out_overflow, out_zero;
    logic [31:0] out_result;
    logic [2:0]  out_cmd;
    logic [2:0]  count;
    logic        sticky_carry, sticky_overflow;
    logic [7:0]  ovf_events;

    logic        in_ready_b, out_valid_b, out_cout_b, out_overflow_b, out_zero_b;
    logic [31:0] out_result_b;
    logic [2:0]  out_cmd_b;
    logic [2:0]  count_b;
    logic        sticky_carry_b, sticky_overflow_b;
    logic [1:0]  ovf_events_b;

    int n_vec;
    int n_bad;

    alu_result_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_cmd(in_cmd), .in_cout(in_cout),
        .in_overflow(in_overflow), .in_zero(in_zero), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_cmd(out_cmd),
        .out_cout(out_cout), .out_overflow(out_overflow), .out_zero(out_zero),
        .count(count), .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow),
        .ovf_events(ovf_events), .clear_sticky(clear_sticky)
    );

    alu_result_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_result(in_result), .in_cmd(in_cmd), .in_cout(in_cout),
        .in_overflow(in_overflow), .in_zero(in_zero), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_result(out_result_b), .out_cmd(out_cmd_b),
        .out_cout(out_cout_b), .out_overflow(out_overflow_b), .out_zero(out_zero_b),
        .count(count_b), .sticky_carry(sticky_carry_b), .sticky_overflow(sticky_overflow_b),
        .ovf_events(ovf_events_b), .clear_sticky(clear_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic [2:0]  cmd;
        logic        co, ov, z, rdy, clr;
        logic [2:0]  e_cnt;
        logic        e_val;
        logic [31:0] e_res;
        logic [2:0]  e_cmd;
        logic        e_co, e_ov, e_z, e_inr, e_sc, e_so;
        logic [7:0]  e_ev;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(
        input logic v, input logic [31:0] res, input logic [2:0] cmd,
        input logic co, input logic ov, input logic z, input logic rdy, input logic clr,
        input logic [2:0] e_cnt, input logic e_val, input logic [31:0] e_res,
        input logic [2:0] e_cmd, input logic e_co, input logic e_ov, input logic e_z,
        input logic e_inr, input logic e_sc, input logic e_so, input logic [7:0] e_ev);
        vec_t t;
        t.v = v; t.res = res; t.cmd = cmd; t.co = co; t.ov = ov; t.z = z;
        t.rdy = rdy; t.clr = clr; t.e_cnt = e_cnt; t.e_val = e_val; t.e_res = e_res;
        t.e_cmd = e_cmd; t.e_co = e_co; t.e_ov = e_ov; t.e_z = e_z; t.e_inr = e_inr;
        t.e_sc = e_sc; t.e_so = e_so; t.e_ev = e_ev;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [2:0] cmd,
                         input logic co, input logic ov, input logic z,
                         input logic rdy, input logic clr);
        in_valid = v; in_result = res; in_cmd = cmd; in_cout = co;
        in_overflow = ov; in_zero = z; out_ready = rdy; clear_sticky = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] snap();
        return 64'({count, out_valid, out_result, out_cmd, out_cout, out_overflow,
                    out_zero, in_ready, sticky_carry, sticky_overflow, ovf_events});
    endfunction

    logic [31:0] q [$];
    int          pushed, popped;
    logic        do_push, rdy, acc, pop;

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(0, 32'h0, 3'b000, 0, 0, 0, 0, 0);

        // Table: masking, FWFT timing, empty-pop, clear. Expected = state after the edge.
        vecs[0] = mk(1, 32'h0000_0005, 3'b010, 1, 1, 0, 0, 0,  1, 1, 32'h0000_0005, 3'b010, 0, 0, 0, 1, 0, 0, 0);
        vecs[1] = mk(0, 32'h0,         3'b000, 0, 0, 0, 1, 0,  0, 0, 32'h0,         3'b000, 0, 0, 0, 1, 0, 0, 0);
        vecs[2] = mk(1, 32'h8000_0000, 3'b000, 0, 1, 0, 0, 0,  1, 1, 32'h8000_0000, 3'b000, 0, 1, 0, 1, 0, 1, 1);
        vecs[3] = mk(1, 32'h0000_0000, 3'b001, 1, 0, 1, 1, 0,  1, 1, 32'h0000_0000, 3'b001, 1, 0, 1, 1, 1, 1, 1);
        vecs[4] = mk(0, 32'h0,         3'b000, 0, 0, 0, 1, 0,  0, 0, 32'h0,         3'b000, 0, 0, 0, 1, 1, 1, 1);
        vecs[5] = mk(0, 32'h0,         3'b000, 0, 0, 0, 1, 0,  0, 0, 32'h0,         3'b000, 0, 0, 0, 1, 1, 1, 1);
        vecs[6] = mk(1, 32'hFFFF_0000, 3'b100, 1, 1, 0, 1, 0,  1, 1, 32'hFFFF_0000, 3'b100, 0, 0, 0, 1, 1, 1, 1);
        vecs[7] = mk(0, 32'h0,         3'b000, 0, 0, 0, 0, 1,  1, 1, 32'hFFFF_0000, 3'b100, 0, 0, 0, 1, 0, 0, 0);
        vecs[8] = mk(0, 32'h0,         3'b000, 0, 0, 0, 1, 0,  0, 0, 32'h0,         3'b000, 0, 0, 0, 1, 0, 0, 0);

        tick();
        check("reset_state", snap(), 64'({3'd0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].res, vecs[i].cmd, vecs[i].co, vecs[i].ov,
                  vecs[i].z, vecs[i].rdy, vecs[i].clr);
            tick();
            check($sformatf("vec%0d", i), snap(),
                  64'({vecs[i].e_cnt, vecs[i].e_val, vecs[i].e_res, vecs[i].e_cmd,
                       vecs[i].e_co, vecs[i].e_ov, vecs[i].e_z, vecs[i].e_inr,
                       vecs[i].e_sc, vecs[i].e_so, vecs[i].e_ev}));
        end

        // Ordering and wrap: push 1..6 while popping on odd cycles from cycle 3.
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 40 && popped < 6; cyc++) begin
            do_push = (pushed < 6);
            rdy     = (cyc >= 3) && (cyc % 2 == 1);
            drive(do_push, 32'(pushed + 1), 3'b111, 0, 0, 0, rdy, 0);
            #1;
            check("ord_in_ready", 64'(in_ready), 64'(q.size() != 4));
            check("ord_count", 64'(count), 64'(q.size()));
            if (q.size() > 0)
                check("ord_head", 64'(out_result), 64'(q[0]));
            acc = do_push && (q.size() != 4);
            pop = rdy && (q.size() > 0);
            tick();
            if (pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (acc) begin
                q.push_back(32'(pushed + 1));
                pushed++;
            end
        end
        check("ord_all_popped", 64'(popped), 64'd6);

        // Full with simultaneous pop request: pop only, in_ready returns next cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'hA0 + 32'(i), 3'b000, 0, 0, 0, 0, 0);
            tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1, 32'hA4, 3'b000, 0, 0, 0, 1, 0);
        tick();
        check("full_pop_count", 64'(count), 64'd3);
        check("full_pop_ready", 64'(in_ready), 64'd1);
        check("full_pop_head", 64'(out_result), 64'hA1);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick();
        check("drain_count", 64'(count), 64'd0);

        // Clear versus set, then saturation on the 2-bit counter instance.
        drive(0, 32'h0, 3'b000, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h10, 3'b001, 0, 1, 0, 1, 0);
            tick();
        end
        check("ev5", 64'(ovf_events), 64'd5);
        check("ev5_so", 64'(sticky_overflow), 64'd1);
        check("ev_sat_pre", 64'(ovf_events_b), 64'd3);
        drive(1, 32'h11, 3'b001, 0, 1, 0, 1, 1);
        tick();
        check("clr_set", 64'({sticky_carry, sticky_overflow, ovf_events}), 64'({1'b0, 1'b1, 8'd1}));
        check("clr_set_sat", 64'(ovf_events_b), 64'd1);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 1, 1);
        tick();
        check("clr_only", 64'({sticky_carry, sticky_overflow, ovf_events}), 64'({1'b0, 1'b0, 8'd0}));
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h20 + 32'(i), 3'b001, 0, 1, 0, 1, 0);
            tick();
        end
        check("sat_cnt2", 64'(ovf_events_b), 64'd3);
        check("sat_cnt8", 64'(ovf_events), 64'd5);

        // Mid-stream asynchronous reset.
        drive(0, 32'h0, 3'b000, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h30 + 32'(i), 3'b000, 1, 1, 0, 0, 0);
            tick();
        end
        check("pre_rst_count", 64'(count), 64'd3);
        drive(0, 32'h0, 3'b000, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        check("async_rst", snap(), 64'({3'd0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}));
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_count", 64'({count, out_valid, in_ready}), 64'({3'd0, 1'b0, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
